// File: rtl/sys_defs.sv
// Shared definitions for the commit controller: ROB geometry, datapath width
// and the commit FSM state type.
package sys_defs;

    // ROB_SZ must stay a power of two so index arithmetic wraps naturally.
    localparam int ROB_SZ = 8;
    localparam int XLEN   = 32;
    localparam int IDX_W  = $clog2(ROB_SZ);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } ROB_CTRL_STATE;

endpackage

// File: rtl/rob_commit_ctrl.sv
// ROB commit controller: tracks completion/mispredict per ROB entry, retires the
// head in order, and sequences branch recovery (redirect, tail undo, drain) and halt.
module rob_commit_ctrl
    import sys_defs::*;
#(
    parameter int RECOVER_LAT = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dispatch_valid,
    input  logic [IDX_W-1:0]    dispatch_idx,
    input  logic                complete_valid,
    input  logic [IDX_W-1:0]    complete_idx,
    input  logic                complete_mispredict,
    input  logic [XLEN-1:0]     complete_target,
    input  logic [IDX_W-1:0]    head_idx,
    input  logic                rob_empty,
    input  logic                head_is_halt,
    output logic                move_head,
    output logic                undo,
    output logic [IDX_W-1:0]    undo_index,
    output logic                redirect_valid,
    output logic [XLEN-1:0]     redirect_pc,
    output logic                dispatch_stall,
    output logic                halted,
    output logic [31:0]         retired_count,
    output ROB_CTRL_STATE       ctrl_state
);

    localparam logic [3:0] DRAIN_CYCLES = 4'(RECOVER_LAT);

    ROB_CTRL_STATE       state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ROB_SZ-1:0]   done_q, done_d;
    logic [ROB_SZ-1:0]   misp_q, misp_d;
    logic [XLEN-1:0]     target_q [ROB_SZ];
    logic [XLEN-1:0]     target_d [ROB_SZ];
    logic [31:0]         retired_q, retired_d;

    assign ctrl_state    = state_q;
    assign retired_count = retired_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        done_d         = done_q;
        misp_d         = misp_q;
        target_d       = target_q;
        retired_d      = retired_q;
        move_head      = 1'b0;
        undo           = 1'b0;
        undo_index     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dispatch_stall = 1'b0;
        halted         = 1'b0;

        case (state_q)
            RUN: begin
                if (!rob_empty && done_q[head_idx]) begin
                    move_head = 1'b1;
                    if (misp_q[head_idx]) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = target_q[head_idx];
                        dispatch_stall = 1'b1;
                        state_d        = RECOVER;
                    end else if (head_is_halt) begin
                        state_d = HALTED;
                    end
                end
                // Results are only accepted here; in recovery they belong to squashed work.
                if (complete_valid) begin
                    done_d[complete_idx]   = 1'b1;
                    misp_d[complete_idx]   = complete_mispredict;
                    target_d[complete_idx] = complete_target;
                end
            end
            RECOVER: begin
                undo           = 1'b1;
                undo_index     = head_idx;
                dispatch_stall = 1'b1;
                done_d         = '0;
                misp_d         = '0;
                cnt_d          = DRAIN_CYCLES;
                state_d        = DRAIN;
            end
            DRAIN: begin
                dispatch_stall = 1'b1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HALTED: begin
                halted         = 1'b1;
                dispatch_stall = 1'b1;
            end
            default: state_d = RUN;
        endcase

        // A fresh allocation always overrides a same-cycle completion on that slot.
        if (dispatch_valid) begin
            done_d[dispatch_idx] = 1'b0;
            misp_d[dispatch_idx] = 1'b0;
        end

        if (move_head) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            cnt_q     <= 4'd0;
            done_q    <= '0;
            misp_q    <= '0;
            retired_q <= 32'd0;
            for (int i = 0; i < ROB_SZ; i++) begin
                target_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            misp_q    <= misp_d;
            retired_q <= retired_d;
            target_q  <= target_d;
        end
    end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the commit rules.
module tb_rob_commit_ctrl;
    import sys_defs::*;

    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic               dispatch_valid, complete_valid, complete_mispredict;
    logic [IDX_W-1:0]   dispatch_idx, complete_idx, head_idx;
    logic [XLEN-1:0]    complete_target;
    logic               rob_empty, head_is_halt;
    logic               move_head, undo, redirect_valid, dispatch_stall, halted;
    logic [IDX_W-1:0]   undo_index;
    logic [XLEN-1:0]    redirect_pc;
    logic [31:0]        retired_count;
    ROB_CTRL_STATE      ctrl_state;

    rob_commit_ctrl #(.RECOVER_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_idx(dispatch_idx),
        .complete_valid(complete_valid), .complete_idx(complete_idx),
        .complete_mispredict(complete_mispredict), .complete_target(complete_target),
        .head_idx(head_idx), .rob_empty(rob_empty), .head_is_halt(head_is_halt),
        .move_head(move_head), .undo(undo), .undo_index(undo_index),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dispatch_stall(dispatch_stall), .halted(halted),
        .retired_count(retired_count), .ctrl_state(ctrl_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // mode: 0 normal, 1 undo cycle, 2 stalling, 3 halted forever
    bit               m_done [ROB_SZ];
    bit               m_misp [ROB_SZ];
    logic [XLEN-1:0]  m_tgt  [ROB_SZ];
    int               m_mode;
    int               m_left;
    logic [31:0]      m_ret;
    logic             e_move, e_redir, e_undo, e_stall, e_halt;
    logic [XLEN-1:0]  e_pc;
    logic [IDX_W-1:0] e_uidx;

    task automatic model_reset();
        for (int i = 0; i < ROB_SZ; i++) begin
            m_done[i] = 0; m_misp[i] = 0; m_tgt[i] = '0;
        end
        m_mode = 0; m_left = 0; m_ret = 0;
    endtask

    task automatic model_predict();
        e_move  = (m_mode == 0) && !rob_empty && m_done[head_idx];
        e_redir = e_move && m_misp[head_idx];
        e_pc    = e_redir ? m_tgt[head_idx] : '0;
        e_undo  = (m_mode == 1);
        e_uidx  = e_undo ? head_idx : '0;
        e_stall = (m_mode != 0) || e_redir;
        e_halt  = (m_mode == 3);
    endtask

    task automatic model_commit();
        case (m_mode)
            0: begin
                if (e_move) m_ret = m_ret + 1;
                if (complete_valid) begin
                    m_done[complete_idx] = 1;
                    m_misp[complete_idx] = complete_mispredict;
                    m_tgt[complete_idx]  = complete_target;
                end
                if (e_redir) m_mode = 1;
                else if (e_move && head_is_halt) m_mode = 3;
            end
            1: begin
                for (int i = 0; i < ROB_SZ; i++) begin m_done[i] = 0; m_misp[i] = 0; end
                m_mode = 2; m_left = LAT;
            end
            2: begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 0;
            end
            default: ;
        endcase
        if (dispatch_valid) begin
            m_done[dispatch_idx] = 0;
            m_misp[dispatch_idx] = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic dv, input int di, input logic cv, input int ci,
                         input logic cm, input logic [XLEN-1:0] ct, input int hd,
                         input logic emp, input logic hlt);
        dispatch_valid = dv; dispatch_idx = IDX_W'(di);
        complete_valid = cv; complete_idx = IDX_W'(ci);
        complete_mispredict = cm; complete_target = ct;
        head_idx = IDX_W'(hd); rob_empty = emp; head_is_halt = hlt;
    endtask

    task automatic drive_idle();
        drive(0, 0, 0, 0, 0, '0, 0, 1, 0);
    endtask

    task automatic settle();
        #1;
        model_predict();
    endtask

    task automatic advance();
        @(posedge clock);
        model_commit();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        drive(1, 2, 1, 2, 1, 32'hdead_beef, 2, 0, 1);
        model_reset();
        #2;
        n_cmp++; if (move_head !== 1'b0) begin n_bad++; $display("FAIL rst_move got %b exp 0", move_head); end
        n_cmp++; if (undo !== 1'b0) begin n_bad++; $display("FAIL rst_undo got %b exp 0", undo); end
        n_cmp++; if (undo_index !== '0) begin n_bad++; $display("FAIL rst_uidx got %0d exp 0", undo_index); end
        n_cmp++; if (redirect_valid !== 1'b0) begin n_bad++; $display("FAIL rst_redir got %b exp 0", redirect_valid); end
        n_cmp++; if (redirect_pc !== '0) begin n_bad++; $display("FAIL rst_pc got %h exp 0", redirect_pc); end
        n_cmp++; if (dispatch_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b exp 0", dispatch_stall); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted got %b exp 0", halted); end
        n_cmp++; if (retired_count !== 32'd0) begin n_bad++; $display("FAIL rst_retired got %0d exp 0", retired_count); end
        n_cmp++; if (ctrl_state !== RUN) begin n_bad++; $display("FAIL rst_state got %0d exp RUN", ctrl_state); end
        @(negedge clock);
        drive_idle();
        reset = 1'b1;
    endtask

    task automatic test_in_order();
        int ord[4] = '{2, 0, 1, 3};
        logic [IDX_W-1:0] exp_q[$];
        logic [IDX_W-1:0] got_q[$];
        logic [IDX_W-1:0] h = '0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, i, 0, 0, 0, '0, 0, (i == 0), 0);
            settle();
            n_cmp++; if (move_head !== e_move) begin n_bad++; $display("FAIL ord_disp_move i=%0d got %b exp %b", i, move_head, e_move); end
            advance();
        end
        for (int k = 0; k < 7; k++) begin
            drive(0, 0, (k < 4), (k < 4) ? ord[k] : 0, 0, '0, int'(h), (h == IDX_W'(4)), 0);
            settle();
            n_cmp++; if (move_head !== e_move) begin n_bad++; $display("FAIL ord_move k=%0d got %b exp %b", k, move_head, e_move); end
            if (move_head === 1'b1) got_q.push_back(head_idx);
            advance();
            if (e_move) h = h + 1'b1;
        end
        exp_q = '{IDX_W'(0), IDX_W'(1), IDX_W'(2), IDX_W'(3)};
        n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL ord_count got %0d exp 4", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            logic [IDX_W-1:0] e = exp_q.pop_front();
            logic [IDX_W-1:0] g = got_q.pop_front();
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL ord_seq got %0d exp %0d", g, e); end
        end
        n_cmp++; if (retired_count !== 32'd4) begin n_bad++; $display("FAIL ord_retired got %0d exp 4", retired_count); end
    endtask

    task automatic test_mispredict();
        do_reset();
        drive(1, 5, 0, 0, 0, '0, 5, 1, 0); settle(); advance();
        drive(1, 6, 0, 0, 0, '0, 5, 0, 0); settle(); advance();
        drive(0, 0, 1, 5, 1, 32'h0000_1040, 5, 0, 0); settle();
        n_cmp++; if (move_head !== 1'b0) begin n_bad++; $display("FAIL mp_early_move got %b exp 0", move_head); end
        advance();
        drive(0, 0, 0, 0, 0, '0, 5, 0, 0); settle();
        n_cmp++; if (move_head !== 1'b1) begin n_bad++; $display("FAIL mp_move got %b exp 1", move_head); end
        n_cmp++; if (redirect_valid !== 1'b1) begin n_bad++; $display("FAIL mp_redir got %b exp 1", redirect_valid); end
        n_cmp++; if (redirect_pc !== 32'h0000_1040) begin n_bad++; $display("FAIL mp_pc got %h exp 00001040", redirect_pc); end
        n_cmp++; if (dispatch_stall !== 1'b1) begin n_bad++; $display("FAIL mp_stall got %b exp 1", dispatch_stall); end
        n_cmp++; if (undo !== 1'b0) begin n_bad++; $display("FAIL mp_undo_early got %b exp 0", undo); end
        advance();
        drive(0, 0, 0, 0, 0, '0, 6, 0, 0); settle();
        n_cmp++; if (undo !== 1'b1) begin n_bad++; $display("FAIL mp_undo got %b exp 1", undo); end
        n_cmp++; if (undo_index !== IDX_W'(6)) begin n_bad++; $display("FAIL mp_uidx got %0d exp 6", undo_index); end
        n_cmp++; if (move_head !== 1'b0 || redirect_valid !== 1'b0) begin n_bad++; $display("FAIL mp_rec_quiet got move %b redir %b exp 0 0", move_head, redirect_valid); end
        advance();
        for (int c = 0; c < LAT; c++) begin
            drive(0, 0, 0, 0, 0, '0, 6, 1, 0); settle();
            n_cmp++; if (dispatch_stall !== 1'b1 || undo !== 1'b0 || move_head !== 1'b0) begin n_bad++; $display("FAIL mp_drain c=%0d got stall %b undo %b move %b exp 1 0 0", c, dispatch_stall, undo, move_head); end
            advance();
        end
        settle();
        n_cmp++; if (dispatch_stall !== 1'b0) begin n_bad++; $display("FAIL mp_resume_stall got %b exp 0", dispatch_stall); end
        n_cmp++; if (ctrl_state !== RUN) begin n_bad++; $display("FAIL mp_resume_state got %0d exp RUN", ctrl_state); end
    endtask

    task automatic test_drain_complete();
        do_reset();
        drive(1, 0, 0, 0, 0, '0, 0, 1, 0); settle(); advance();
        drive(0, 0, 1, 0, 1, 32'h0000_2000, 0, 0, 0); settle(); advance();
        drive(0, 0, 0, 0, 0, '0, 0, 0, 0); settle(); advance();
        drive(0, 0, 0, 0, 0, '0, 1, 1, 0); settle(); advance();
        drive(0, 0, 1, 7, 0, 32'h0000_3000, 1, 1, 0); settle();
        n_cmp++; if (dispatch_stall !== 1'b1) begin n_bad++; $display("FAIL dc_stall got %b exp 1", dispatch_stall); end
        advance();
        drive_idle(); settle(); advance();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 0, '0, 7, 0, 0); settle();
            n_cmp++; if (move_head !== 1'b0) begin n_bad++; $display("FAIL dc_move c=%0d got %b exp 0", c, move_head); end
            advance();
        end
        n_cmp++; if (retired_count !== 32'd1) begin n_bad++; $display("FAIL dc_retired got %0d exp 1", retired_count); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(1, 3, 1, 3, 0, 32'h0000_0abc, 3, 1, 0); settle(); advance();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 0, '0, 3, 0, 0); settle();
            n_cmp++; if (move_head !== 1'b0) begin n_bad++; $display("FAIL sc_move c=%0d got %b exp 0", c, move_head); end
            advance();
        end
        drive(0, 0, 1, 3, 0, '0, 3, 0, 0); settle(); advance();
        drive(0, 0, 0, 0, 0, '0, 3, 0, 0); settle();
        n_cmp++; if (move_head !== 1'b1) begin n_bad++; $display("FAIL sc_later_move got %b exp 1", move_head); end
        advance();
    endtask

    task automatic test_halt();
        do_reset();
        drive(0, 0, 1, 2, 0, '0, 2, 0, 1); settle(); advance();
        drive(0, 0, 0, 0, 0, '0, 2, 0, 1); settle();
        n_cmp++; if (move_head !== 1'b1) begin n_bad++; $display("FAIL ht_move got %b exp 1", move_head); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL ht_early got %b exp 0", halted); end
        advance();
        for (int c = 0; c < 12; c++) begin
            drive(0, 0, (c == 0), 3, 0, '0, 3, 0, 0); settle();
            n_cmp++; if (halted !== 1'b1 || dispatch_stall !== 1'b1 || move_head !== 1'b0 || undo !== 1'b0)
                begin n_bad++; $display("FAIL ht_hold c=%0d got halted %b stall %b move %b undo %b exp 1 1 0 0", c, halted, dispatch_stall, move_head, undo); end
            advance();
        end
        n_cmp++; if (retired_count !== 32'd1) begin n_bad++; $display("FAIL ht_retired got %0d exp 1", retired_count); end
    endtask

    task automatic test_reset_in_drain();
        do_reset();
        drive(1, 4, 0, 0, 0, '0, 4, 1, 0); settle(); advance();
        drive(0, 0, 1, 4, 1, 32'h0000_3000, 4, 0, 0); settle(); advance();
        drive(0, 0, 0, 0, 0, '0, 4, 0, 0); settle(); advance();
        drive(0, 0, 0, 0, 0, '0, 5, 1, 0); settle(); advance();
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (dispatch_stall !== 1'b0 || undo !== 1'b0 || move_head !== 1'b0 || redirect_valid !== 1'b0)
            begin n_bad++; $display("FAIL rd_outs got stall %b undo %b move %b redir %b exp 0 0 0 0", dispatch_stall, undo, move_head, redirect_valid); end
        n_cmp++; if (ctrl_state !== RUN) begin n_bad++; $display("FAIL rd_state got %0d exp RUN", ctrl_state); end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 0, '0, 5, 1, 0); settle();
            n_cmp++; if (undo !== 1'b0 || dispatch_stall !== 1'b0) begin n_bad++; $display("FAIL rd_after c=%0d got undo %b stall %b exp 0 0", c, undo, dispatch_stall); end
            advance();
        end
    endtask

    task automatic test_random();
        logic [IDX_W-1:0] h;
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            h = '0;
            for (int c = 0; c < 120; c++) begin
                drive($urandom_range(0, 1), $urandom_range(0, ROB_SZ - 1),
                      ($urandom_range(0, 9) < 7), $urandom_range(0, ROB_SZ - 1),
                      ($urandom_range(0, 7) == 0), $urandom, int'(h),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 60) == 0));
                settle();
                n_cmp++; if (move_head !== e_move) begin n_bad++; $display("FAIL rnd_move b%0d c%0d got %b exp %b", blk, c, move_head, e_move); end
                n_cmp++; if (redirect_valid !== e_redir) begin n_bad++; $display("FAIL rnd_redir b%0d c%0d got %b exp %b", blk, c, redirect_valid, e_redir); end
                n_cmp++; if (redirect_pc !== e_pc) begin n_bad++; $display("FAIL rnd_pc b%0d c%0d got %h exp %h", blk, c, redirect_pc, e_pc); end
                n_cmp++; if (undo !== e_undo) begin n_bad++; $display("FAIL rnd_undo b%0d c%0d got %b exp %b", blk, c, undo, e_undo); end
                n_cmp++; if (undo_index !== e_uidx) begin n_bad++; $display("FAIL rnd_uidx b%0d c%0d got %0d exp %0d", blk, c, undo_index, e_uidx); end
                n_cmp++; if (dispatch_stall !== e_stall) begin n_bad++; $display("FAIL rnd_stall b%0d c%0d got %b exp %b", blk, c, dispatch_stall, e_stall); end
                n_cmp++; if (halted !== e_halt) begin n_bad++; $display("FAIL rnd_halted b%0d c%0d got %b exp %b", blk, c, halted, e_halt); end
                n_cmp++; if (retired_count !== m_ret) begin n_bad++; $display("FAIL rnd_retired b%0d c%0d got %0d exp %0d", blk, c, retired_count, m_ret); end
                advance();
                if (e_move) h = h + 1'b1;
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clock);
        test_reset();
        test_in_order();
        test_mispredict();
        test_drain_complete();
        test_same_cycle();
        test_halt();
        test_reset_in_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
